// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and length limits.
package boot_pkg;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned MAX_LEN    = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RELEASE,
    S_RUN,
    S_HALTED,
    S_ERR
  } state_e;

  // High length byte alone already puts LEN at or beyond the addressable memory.
  function automatic logic len_hi_too_big(input logic [7:0] hi, input int unsigned addr_w);
    return (32'(hi) << 8) >= (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Streams a length-prefixed program into memory from address 0, holds the CPU in reset
// while loading and releases it afterwards. BOOT_CHECKSUM_EN adds a trailing sum byte.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [7:0]          hold_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          sum_q;
`endif

  logic accept;
  logic last_byte;
  logic hold_done;

  assign accept    = in_valid & in_ready;
  assign last_byte = (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));
  assign hold_done = (hold_q == 8'(RST_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LEN_HI, S_HALTED: begin
        if (accept) state_d = len_hi_too_big(in_data, ADDR_W) ? S_ERR : S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if ({len_hi_q, in_data} == '0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_RELEASE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && last_byte) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_RELEASE;
`endif
        end
      end
      S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
        if (accept) state_d = (in_data == sum_q) ? S_RELEASE : S_ERR;
`else
        state_d = S_ERR;
`endif
      end
      S_RELEASE: if (hold_done) state_d = S_RUN;
      S_RUN:     if (cpu_halt) state_d = S_HALTED;
      S_ERR:     state_d = S_ERR;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      S_LEN_HI:  in_ready = 1'b1;
      S_LEN_LO, S_DATA, S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_RELEASE: busy = 1'b1;
      S_RUN:     cpu_rst = 1'b0;
      S_HALTED: begin
        in_ready = 1'b1;
        cpu_rst  = 1'b0;
        done     = 1'b1;
      end
      S_ERR:     err = 1'b1;
    endcase
  end

  // Datapath: the write strobe is registered so it lands the cycle after the accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      mem_wr_q <= 1'b0;
      unique case (state_q)
        S_LEN_HI, S_HALTED: if (accept) len_hi_q <= in_data;
        S_LEN_LO: begin
          if (accept) begin
            len_q  <= {len_hi_q, in_data};
            cnt_q  <= '0;
            hold_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q  <= '0;
`endif
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= cnt_q;
            mem_wdata_q <= DATA_W'(in_data);
            cnt_q       <= cnt_q + ADDR_W'(1);
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= sum_q + in_data;
`endif
          end
        end
        S_RELEASE: hold_q <= hold_q + 8'd1;
        S_CSUM, S_RUN, S_ERR: ;
      endcase
    end
  end

  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader; honours BOOT_CHECKSUM_EN for frame trailers.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wr;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [12:0] wa[$];
  logic [7:0]  wd[$];

  boot_loader #(
    .ADDR_W  (13),
    .DATA_W  (8),
    .RST_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .cpu_halt (cpu_halt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cpu_halt = 1'b0;
    step();
    step();
    rst = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_release(input string tag);
    int n;
    n = 0;
    while (cpu_rst && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(cpu_rst), 32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, 32'(wa.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int bad;
    logic [7:0] gaps[5];
    logic [7:0] d4[5];

    // 1: reset state, then a three-byte frame at full rate
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    send_byte(8'h00, 0);
    check("busy_len_lo", 32'(busy), 32'd1);
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h31, 0);
`else
    check("t1_last_strobe", 32'(mem_wr), 32'd1);
`endif
    check("t1_release_rst", 32'(cpu_rst), 32'd1);
    check("t1_release_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    check("t1_hold3", 32'(cpu_rst), 32'd1);
    step();
    check("t1_hold4", 32'(cpu_rst), 32'd0);
    check("t1_busy_run", 32'(busy), 32'd0);
    check_writes("t1", '{8'hAA, 8'hBB, 8'hCC});

    // 2: empty frame
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    check("t2_busy_rel", 32'(busy), 32'd1);
    check("t2_rst_rel", 32'(cpu_rst), 32'd1);
    repeat (3) step();
    check("t2_hold3", 32'(cpu_rst), 32'd1);
    step();
    check("t2_hold4", 32'(cpu_rst), 32'd0);
    check("t2_busy_run", 32'(busy), 32'd0);
    check("t2_no_writes", 32'(wa.size()), 32'd0);

    // 3: oversize length is a sticky error
    do_reset();
    send_byte(8'h20, 0);
    check("t3_err", 32'(err), 32'd1);
    check("t3_ready", 32'(in_ready), 32'd0);
    check("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    bad = 0;
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (50) begin
      step();
      if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || mem_wr !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    check("t3_sticky", 32'(bad), 32'd0);
    do_reset();
    check("t3_clr_err", 32'(err), 32'd0);
    check("t3_clr_ready", 32'(in_ready), 32'd1);
    check("t3_clr_busy", 32'(busy), 32'd0);

    // 4: five data bytes with idle gaps
    do_reset();
    gaps = '{8'd2, 8'd0, 8'd3, 8'd1, 8'd0};
    d4   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_byte(8'h00, 1);
    send_byte(8'h05, 2);
    for (int i = 0; i < 5; i++) send_byte(d4[i], int'(gaps[i]));
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'hFF, 1);
`endif
    wait_release("t4_release");
    check_writes("t4", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    check("t4_run_ready", 32'(in_ready), 32'd0);

    // 5: halt, then a new load from the halted state
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    check("t5_done", 32'(done), 32'd1);
    check("t5_ready", 32'(in_ready), 32'd1);
    check("t5_cpu_run", 32'(cpu_rst), 32'd0);
    wa.delete();
    wd.delete();
    send_byte(8'h00, 0);
    check("t5_reload_rst", 32'(cpu_rst), 32'd1);
    check("t5_reload_done", 32'(done), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h5A, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h5A, 0);
`endif
    wait_release("t5_release");
    check_writes("t5", '{8'h5A});

    // reset in the middle of the data phase
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mid_ready", 32'(in_ready), 32'd1);
    check("mid_busy_clr", 32'(busy), 32'd0);
    check("mid_wr_clr", 32'(mem_wr), 32'd0);
    wa.delete();
    wd.delete();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h77, 0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h77, 0);
`endif
    wait_release("mid_release");
    check_writes("mid", '{8'h77});

`ifdef BOOT_CHECKSUM_EN
    // 6: trailer match and mismatch
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    wait_release("t6_release");
    check("t6_ok_err", 32'(err), 32'd0);
    check_writes("t6", '{8'h10, 8'h20});
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h31, 0);
    check("t6_bad_err", 32'(err), 32'd1);
    repeat (10) step();
    check("t6_bad_rst", 32'(cpu_rst), 32'd1);
    check("t6_bad_sticky", 32'(err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
